gbt_rx_frameclk_dps_ctrl: RTL and testbench

// Sequencer for the dynamic-phase-shift (DPS) port of the RX frame-clock PLL.

---
 rtl/gbt_rx_frameclk_dps_ctrl_if.sv | 21 ++
 rtl/gbt_rx_frameclk_dps_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_gbt_rx_frameclk_dps_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gbt_rx_frameclk_dps_ctrl_if.sv
// Request channel into the RX frame-clock DPS sequencer.
// The master is the phase aligner and the slave is the sequencer.
interface gbt_rx_frameclk_dps_ctrl_if #(
  parameter int STEP_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_cntsel;
  logic              req_updn;
  logic [STEP_W-1:0] req_steps;

  modport master (
    output req_valid, req_cntsel, req_updn, req_steps,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_cntsel, req_updn, req_steps,
    output req_ready
  );
endinterface

// File: rtl/gbt_rx_frameclk_dps_ctrl.sv
// Dynamic-phase-shift sequencer for the RX frame-clock PLL: steps one counter
// N times via phase_en/phase_done and tracks the net signed phase per counter.
module gbt_rx_frameclk_dps_ctrl #(
  parameter int NUM_CNT      = 1,
  parameter int STEP_W       = 8,
  parameter int POS_W        = 10,
  parameter int EN_CYCLES    = 2,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                            scanclk,
  input  logic                            rst,
  gbt_rx_frameclk_dps_ctrl_if.slave       req,
  input  logic                            pll_locked,
  output logic                            phase_en,
  output logic                            updn,
  output logic [4:0]                      cntsel,
  input  logic                            phase_done,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [1:0]                      err_code,
  input  logic [4:0]                      rd_sel,
  output logic signed [POS_W-1:0]         rd_pos
);

  localparam int                       EN_W     = $clog2(EN_CYCLES + 1);
  localparam int                       TMR_W    = $clog2(DONE_TIMEOUT + 1);
  localparam logic [4:0]               NUM_CNT_L = 5'(NUM_CNT);
  localparam logic [EN_W-1:0]          EN_LAST  = EN_W'(EN_CYCLES - 1);
  localparam logic [TMR_W-1:0]         TMR_LAST = TMR_W'(DONE_TIMEOUT - 1);
  localparam logic signed [POS_W-1:0]  POS_ONE  = POS_W'(1);
  localparam logic [1:0] ERR_NONE = 2'd0, ERR_TIMEOUT = 2'd1, ERR_CNTSEL = 2'd2, ERR_LOCK = 2'd3;

  typedef enum logic [2:0] {IDLE, CHECK, PULSE, WAIT_LO, WAIT_HI, FINISH} state_t;

  state_t                   state_q, state_d;
  logic [4:0]               cnt_q, cnt_d;
  logic                     updn_q, updn_d;
  logic [STEP_W-1:0]        rem_q, rem_d;
  logic [EN_W-1:0]          en_q, en_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic                     err_q, err_d;
  logic [1:0]               code_q, code_d;
  logic                     step_ok;
  logic signed [POS_W-1:0]  pos_q [NUM_CNT];
  logic signed [POS_W-1:0]  rd_pos_q, rd_pos_d;

  // Positions wrap modulo 2^POS_W; the aligner only cares about relative moves.
  function automatic logic signed [POS_W-1:0] pos_step(input logic signed [POS_W-1:0] p,
                                                       input logic up);
    pos_step = up ? p + POS_ONE : p - POS_ONE;
  endfunction

  assign req.req_ready = (state_q == IDLE) && pll_locked;
  assign phase_en      = (state_q == PULSE) && pll_locked;
  assign busy          = (state_q == CHECK) || (state_q == PULSE) ||
                         (state_q == WAIT_LO) || (state_q == WAIT_HI);
  assign done          = (state_q == FINISH);
  assign updn          = updn_q;
  assign cntsel        = cnt_q;
  assign err           = err_q;
  assign err_code      = code_q;
  assign rd_pos        = rd_pos_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    updn_d  = updn_q;
    rem_d   = rem_q;
    en_d    = en_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    code_d  = code_q;
    step_ok = 1'b0;
    case (state_q)
      IDLE: if (req.req_valid && req.req_ready) begin
        cnt_d   = req.req_cntsel;
        updn_d  = req.req_updn;
        rem_d   = req.req_steps;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        state_d = CHECK;
      end
      CHECK: begin
        if (cnt_q >= NUM_CNT_L) begin
          code_d  = ERR_CNTSEL;
          state_d = FINISH;
        end else if (rem_q == '0) begin
          state_d = FINISH;
        end else begin
          en_d    = '0;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (!pll_locked) begin
          code_d  = ERR_LOCK;
          state_d = FINISH;
        end else if (en_q == EN_LAST) begin
          tmr_d   = '0;
          state_d = WAIT_LO;
        end else begin
          en_d = en_q + EN_W'(1);
        end
      end
      WAIT_LO: begin
        if (!pll_locked) begin
          code_d  = ERR_LOCK;
          state_d = FINISH;
        end else if (!phase_done) begin
          tmr_d   = '0;
          state_d = WAIT_HI;
        end else if (tmr_q == TMR_LAST) begin
          code_d  = ERR_TIMEOUT;
          state_d = FINISH;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      WAIT_HI: begin
        if (!pll_locked) begin
          code_d  = ERR_LOCK;
          state_d = FINISH;
        end else if (phase_done) begin
          step_ok = 1'b1;
          rem_d   = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) begin
            state_d = FINISH;
          end else begin
            en_d    = '0;
            state_d = PULSE;
          end
        end else if (tmr_q == TMR_LAST) begin
          code_d  = ERR_TIMEOUT;
          state_d = FINISH;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      FINISH: begin
        err_d   = (code_q != ERR_NONE);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_pos_d = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_sel == 5'(i)) rd_pos_d = pos_q[i];
    end
  end

  always_ff @(posedge scanclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      updn_q   <= 1'b0;
      rem_q    <= '0;
      en_q     <= '0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      rd_pos_q <= '0;
      for (int i = 0; i < NUM_CNT; i++) pos_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      updn_q   <= updn_d;
      rem_q    <= rem_d;
      en_q     <= en_d;
      tmr_q    <= tmr_d;
      err_q    <= err_d;
      code_q   <= code_d;
      rd_pos_q <= rd_pos_d;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (step_ok && (cnt_q == 5'(i))) pos_q[i] <= pos_step(pos_q[i], updn_q);
      end
    end
  end

endmodule

// File: tb/tb_gbt_rx_frameclk_dps_ctrl.sv
// Directed bench for the RX frame-clock DPS sequencer with a simple PLL
// phase_done model (low for 4 cycles after each phase_en pulse).
module tb_gbt_rx_frameclk_dps_ctrl;

  logic              scanclk = 1'b0;
  logic              rst;
  logic              pll_locked;
  logic              phase_en;
  logic              updn;
  logic [4:0]        cntsel;
  logic              phase_done;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [4:0]        rd_sel;
  logic signed [9:0] rd_pos;

  int checks = 0;
  int errors = 0;

  // PLL model and output monitors
  logic pe_prev   = 1'b0;
  bit   pll_mode  = 1'b0;
  int   lo_cnt    = 0;
  int   hi_len    = 0;
  int   pulse_cnt = 0;
  int   bad_w     = 0;
  int   done_cnt  = 0;

  gbt_rx_frameclk_dps_ctrl_if #(.STEP_W(8)) req_if ();

  gbt_rx_frameclk_dps_ctrl dut (
    .scanclk    (scanclk),
    .rst        (rst),
    .req        (req_if.slave),
    .pll_locked (pll_locked),
    .phase_en   (phase_en),
    .updn       (updn),
    .cntsel     (cntsel),
    .phase_done (phase_done),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .rd_sel     (rd_sel),
    .rd_pos     (rd_pos)
  );

  always #5 scanclk = ~scanclk;

  assign phase_done = (lo_cnt == 0);

  always @(posedge scanclk) begin
    pe_prev <= phase_en;
    if (phase_en && !pe_prev) pulse_cnt <= pulse_cnt + 1;
    if (phase_en) hi_len <= pe_prev ? hi_len + 1 : 1;
    if (!phase_en && pe_prev && hi_len != 2) bad_w <= bad_w + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (!phase_en && pe_prev && !pll_mode) lo_cnt <= 4;
    else if (lo_cnt != 0) lo_cnt <= lo_cnt - 1;
  end

  task automatic do_req(input logic [4:0] c, input logic u, input logic [7:0] s);
    int n;
    n = 0;
    while (!req_if.req_ready && n < 100) begin
      @(negedge scanclk);
      n++;
    end
    req_if.req_valid  = 1'b1;
    req_if.req_cntsel = c;
    req_if.req_updn   = u;
    req_if.req_steps  = s;
    @(posedge scanclk);
    @(negedge scanclk);
    req_if.req_valid = 1'b0;
  endtask

  // lat = cycles from the accepting edge to the done cycle, -1 if never seen
  task automatic wait_done(input int budget, output int lat);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge scanclk);
      n++;
    end
    lat = done ? n + 1 : -1;
  endtask

  task automatic read_pos(input logic [4:0] sel, output logic signed [9:0] v);
    rd_sel = sel;
    @(negedge scanclk);
    v = rd_pos;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge scanclk);
    checks++;
    if ({phase_en, busy, done, err, err_code, updn} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000", {phase_en, busy, done, err, err_code, updn});
    end
    checks++;
    if (cntsel !== 5'd0) begin
      errors++;
      $display("FAIL reset_cntsel got %0d want 0", cntsel);
    end
    checks++;
    if (rd_pos !== 10'sd0) begin
      errors++;
      $display("FAIL reset_rd_pos got %0d want 0", rd_pos);
    end
    rst = 1'b0;
    @(negedge scanclk);
    checks++;
    if (req_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %0b want 1", req_if.req_ready);
    end
  endtask

  task automatic test_up3;
    int p0, w0, d0, lat;
    logic signed [9:0] v;
    p0 = pulse_cnt; w0 = bad_w; d0 = done_cnt;
    do_req(5'd0, 1'b1, 8'd3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL up3_busy got %0b want 1", busy);
    end
    checks++;
    if (updn !== 1'b1) begin
      errors++;
      $display("FAIL up3_updn got %0b want 1", updn);
    end
    wait_done(200, lat);
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL up3_done got none want done within 200 cycles");
    end
    @(negedge scanclk);
    checks++;
    if (pulse_cnt - p0 !== 3) begin
      errors++;
      $display("FAIL up3_pulses got %0d want 3", pulse_cnt - p0);
    end
    checks++;
    if (bad_w - w0 !== 0) begin
      errors++;
      $display("FAIL up3_width got %0d bad pulses want 0", bad_w - w0);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL up3_done_count got %0d want 1", done_cnt - d0);
    end
    checks++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL up3_err got %0b/%0d want 0/0", err, err_code);
    end
    read_pos(5'd0, v);
    checks++;
    if (v !== 10'sd3) begin
      errors++;
      $display("FAIL up3_pos got %0d want 3", v);
    end
  endtask

  task automatic test_down5;
    int p0, w0, lat;
    logic signed [9:0] v;
    p0 = pulse_cnt; w0 = bad_w;
    do_req(5'd0, 1'b0, 8'd5);
    wait_done(300, lat);
    @(negedge scanclk);
    checks++;
    if (lat < 0 || pulse_cnt - p0 !== 5 || bad_w - w0 !== 0) begin
      errors++;
      $display("FAIL down5_pulses got lat %0d pulses %0d bad %0d want 5 pulses", lat, pulse_cnt - p0, bad_w - w0);
    end
    read_pos(5'd0, v);
    checks++;
    if (v !== -10'sd2) begin
      errors++;
      $display("FAIL down5_pos got %0d want -2", v);
    end
  endtask

  // 520 more steps down from -2 gives -522, which wraps to +502 in 10 bits
  task automatic test_wrap;
    int l1, l2, l3;
    logic signed [9:0] v;
    do_req(5'd0, 1'b0, 8'd255);
    wait_done(3000, l1);
    do_req(5'd0, 1'b0, 8'd255);
    wait_done(3000, l2);
    do_req(5'd0, 1'b0, 8'd10);
    wait_done(300, l3);
    @(negedge scanclk);
    checks++;
    if (l1 < 0 || l2 < 0 || l3 < 0) begin
      errors++;
      $display("FAIL wrap_done got lat %0d %0d %0d want all done", l1, l2, l3);
    end
    read_pos(5'd0, v);
    checks++;
    if (v !== 10'sd502) begin
      errors++;
      $display("FAIL wrap_pos got %0d want 502", v);
    end
  endtask

  task automatic test_bad_cntsel;
    int p0, lat;
    logic signed [9:0] v;
    p0 = pulse_cnt;
    do_req(5'd1, 1'b1, 8'd3);
    wait_done(50, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL badsel_latency got %0d want 2", lat);
    end
    checks++;
    if (cntsel !== 5'd1) begin
      errors++;
      $display("FAIL badsel_cntsel_hold got %0d want 1", cntsel);
    end
    @(negedge scanclk);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd2) begin
      errors++;
      $display("FAIL badsel_err got %0b/%0d want 1/2", err, err_code);
    end
    checks++;
    if (pulse_cnt - p0 !== 0) begin
      errors++;
      $display("FAIL badsel_pulses got %0d want 0", pulse_cnt - p0);
    end
    read_pos(5'd1, v);
    checks++;
    if (v !== 10'sd0) begin
      errors++;
      $display("FAIL rd_out_of_range got %0d want 0", v);
    end
  endtask

  task automatic test_zero_steps;
    int p0, lat;
    logic signed [9:0] v;
    p0 = pulse_cnt;
    do_req(5'd0, 1'b1, 8'd0);
    checks++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL zero_err_clear got %0b/%0d want 0/0", err, err_code);
    end
    wait_done(50, lat);
    @(negedge scanclk);
    checks++;
    if (lat !== 2 || pulse_cnt - p0 !== 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL zero_steps got lat %0d pulses %0d err %0b want 2/0/0", lat, pulse_cnt - p0, err);
    end
    read_pos(5'd0, v);
    checks++;
    if (v !== 10'sd502) begin
      errors++;
      $display("FAIL zero_pos got %0d want 502", v);
    end
  endtask

  // 1 CHECK + 2 PULSE + 255 WAIT_LO cycles, done in the following cycle
  task automatic test_timeout;
    int p0, lat;
    logic signed [9:0] v;
    p0 = pulse_cnt;
    pll_mode = 1'b1;
    do_req(5'd0, 1'b1, 8'd1);
    wait_done(400, lat);
    checks++;
    if (lat !== 259) begin
      errors++;
      $display("FAIL timeout_latency got %0d want 259", lat);
    end
    pll_mode = 1'b0;
    @(negedge scanclk);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd1) begin
      errors++;
      $display("FAIL timeout_err got %0b/%0d want 1/1", err, err_code);
    end
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL timeout_pulses got %0d want 1", pulse_cnt - p0);
    end
    read_pos(5'd0, v);
    checks++;
    if (v !== 10'sd502) begin
      errors++;
      $display("FAIL timeout_pos got %0d want 502", v);
    end
    do_req(5'd0, 1'b1, 8'd0);
    checks++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL timeout_clear got %0b/%0d want 0/0", err, err_code);
    end
    wait_done(50, lat);
    @(negedge scanclk);
  endtask

  task automatic test_rst_midreq;
    int n;
    logic signed [9:0] v;
    rd_sel = 5'd0;
    do_req(5'd0, 1'b1, 8'd4);
    n = 0;
    while (!phase_en && n < 50) begin
      @(negedge scanclk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({phase_en, busy, done, updn, err} !== 5'b0 || cntsel !== 5'd0 || rd_pos !== 10'sd0) begin
      errors++;
      $display("FAIL rst_async got pe %0b busy %0b done %0b updn %0b err %0b cntsel %0d rd_pos %0d want all 0",
               phase_en, busy, done, updn, err, cntsel, rd_pos);
    end
    @(negedge scanclk);
    rst = 1'b0;
    repeat (10) @(negedge scanclk);
    read_pos(5'd0, v);
    checks++;
    if (v !== 10'sd0) begin
      errors++;
      $display("FAIL rst_pos got %0d want 0", v);
    end
  endtask

  task automatic test_lost_lock;
    int rises, n, lat;
    logic prev;
    logic signed [9:0] v;
    do_req(5'd0, 1'b1, 8'd4);
    rises = 0; n = 0; prev = 1'b0;
    while (rises < 2 && n < 200) begin
      if (phase_en && !prev) rises++;
      prev = phase_en;
      if (rises < 2) begin
        @(negedge scanclk);
        n++;
      end
    end
    pll_locked = 1'b0;
    #1;
    checks++;
    if (phase_en !== 1'b0 || rises !== 2) begin
      errors++;
      $display("FAIL lock_gate got phase_en %0b rises %0d want 0 and 2", phase_en, rises);
    end
    @(negedge scanclk);
    wait_done(50, lat);
    checks++;
    if (lat < 0 || err_code !== 2'd3) begin
      errors++;
      $display("FAIL lock_code got lat %0d code %0d want 3", lat, err_code);
    end
    @(negedge scanclk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL lock_err got %0b want 1", err);
    end
    pll_locked = 1'b1;
    read_pos(5'd0, v);
    checks++;
    if (v !== 10'sd1) begin
      errors++;
      $display("FAIL lock_pos got %0d want 1", v);
    end
  endtask

  initial begin
    rst               = 1'b1;
    pll_locked        = 1'b1;
    rd_sel            = 5'd0;
    req_if.req_valid  = 1'b0;
    req_if.req_cntsel = 5'd0;
    req_if.req_updn   = 1'b0;
    req_if.req_steps  = 8'd0;
    @(negedge scanclk);
    test_reset();
    test_up3();
    test_down5();
    test_wrap();
    test_bad_cntsel();
    test_zero_steps();
    test_timeout();
    test_rst_midreq();
    test_lost_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
